// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory bus initiator: FSM state encoding and the
// read/write select encoding used by the synchronous memory.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_initiator_if.sv
// Request, write-stream, read-stream and memory-port signals of the initiator.
// master is the initiator's view; slave is the core/loader plus memory side.
interface mem_initiator_if #(
    parameter int addr_width = 8,
    parameter int data_width = 16,
    parameter int len_width  = addr_width + 1
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [addr_width-1:0] req_addr;
    logic [len_width-1:0]  req_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [data_width-1:0] wr_data;

    logic                  rd_valid;
    logic [data_width-1:0] rd_data;
    logic                  rd_last;
    logic                  done;

    logic [addr_width-1:0] m_addr;
    logic                  m_ce;
    logic                  m_rw;
    logic [data_width-1:0] m_wdata;
    logic [data_width-1:0] m_rdata;

    modport master (
        input  req_valid, req_rw, req_addr, req_len,
        input  wr_valid, wr_data,
        input  m_rdata,
        output req_ready, wr_ready,
        output rd_valid, rd_data, rd_last, done,
        output m_addr, m_ce, m_rw, m_wdata
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_len,
        output wr_valid, wr_data,
        output m_rdata,
        input  req_ready, wr_ready,
        input  rd_valid, rd_data, rd_last, done,
        input  m_addr, m_ce, m_rw, m_wdata
    );

endinterface

// File: rtl/mem_initiator.sv
// Burst initiator for the single-port synchronous memory: turns valid/ready burst
// requests into memory cycles and returns read data as a stream after the memory's latency.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 16,
    parameter int len_width  = addr_width + 1
) (
    input  logic            clk,
    input  logic            clr,
    mem_initiator_if.master bus
);

    state_t                state;
    logic [addr_width-1:0] cur_addr;
    logic [len_width-1:0]  remaining;
    logic                  issue_last;
    logic                  pipe_valid;
    logic                  pipe_last;
    logic                  req_fire;
    logic                  wr_fire;
    logic                  last_beat;
    logic                  read_slot;
    logic [data_width-1:0] wr_word;

    assign bus.req_ready = (state == IDLE);
    assign bus.wr_ready  = (state == WRITE);

    assign req_fire  = bus.req_valid && (state == IDLE);
    assign wr_fire   = bus.wr_valid && (state == WRITE);
    assign last_beat = (remaining == len_width'(1));
    assign read_slot = bus.m_ce && (bus.m_rw == RW_READ);
    assign wr_word   = bus.wr_data;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            issue_last  <= 1'b0;
            pipe_valid  <= 1'b0;
            pipe_last   <= 1'b0;
            bus.m_ce    <= 1'b0;
            bus.m_rw    <= RW_READ;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data <= '0;
            bus.rd_last <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            // Stage 1 lines up with m_rdata being driven; stage 2 is the output register.
            pipe_valid   <= read_slot;
            pipe_last    <= read_slot && issue_last;
            bus.rd_valid <= pipe_valid;
            bus.rd_last  <= pipe_last;
            bus.done     <= pipe_last;
            if (pipe_valid) begin
                bus.rd_data <= bus.m_rdata;
            end

            bus.m_ce   <= 1'b0;
            bus.m_rw   <= RW_READ;
            issue_last <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (bus.req_len == '0) begin
                            bus.done <= 1'b1;
                        end else if (bus.req_rw == RW_READ) begin
                            // The first read goes out on acceptance so m_ce rises in the next cycle.
                            bus.m_ce   <= 1'b1;
                            bus.m_addr <= bus.req_addr;
                            cur_addr   <= bus.req_addr + 1'b1;
                            remaining  <= bus.req_len - 1'b1;
                            issue_last <= (bus.req_len == len_width'(1));
                            state      <= (bus.req_len == len_width'(1)) ? DRAIN : READ;
                        end else begin
                            cur_addr  <= bus.req_addr;
                            remaining <= bus.req_len;
                            state     <= WRITE;
                        end
                    end
                end

                READ: begin
                    bus.m_ce   <= 1'b1;
                    bus.m_addr <= cur_addr;
                    cur_addr   <= cur_addr + 1'b1;
                    remaining  <= remaining - 1'b1;
                    issue_last <= last_beat;
                    if (last_beat) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (bus.rd_last) begin
                        state <= IDLE;
                    end
                end

                WRITE: begin
                    if (wr_fire) begin
                        bus.m_ce    <= 1'b1;
                        bus.m_rw    <= RW_WRITE;
                        bus.m_addr  <= cur_addr;
                        bus.m_wdata <= wr_word;
                        cur_addr    <= cur_addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                        if (last_beat) begin
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a per-cycle expectation table built from the
// burst timing rules, a behavioural memory, and literal spot checks on a recorded trace.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    localparam int NCYC = 1024;

    typedef struct {
        logic        ce;
        logic        rw;
        logic        rw_chk;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        rdv;
        logic [15:0] rdata;
        logic        last;
        logic        done;
        logic        rr;
        logic        wrr;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   free_cyc = 0;
    bit   cmp_en = 1'b0;

    exp_t        exp_tab[NCYC];
    exp_t        cur_e;
    logic [15:0] ref_mem[256];
    logic [15:0] ram[256];
    logic [15:0] rdq = 16'h0000;
    logic        rd_slot = 1'b0;

    logic        tr_ce[NCYC];
    logic [7:0]  tr_addr[NCYC];
    logic [15:0] tr_wdata[NCYC];
    logic        tr_rdv[NCYC];
    logic [15:0] tr_rdata[NCYC];
    logic        tr_last[NCYC];
    logic        tr_done[NCYC];
    logic        tr_rr[NCYC];

    mem_initiator_if bus ();

    mem_initiator dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int a);
        case (a)
            0:  return 16'b0011100000000011;
            1:  return 16'h4801;
            2:  return 16'h5002;
            3:  return 16'h2403;
            4:  return 16'h6C04;
            5:  return 16'h3905;
            6:  return 16'h7006;
            7:  return 16'h8807;
            8:  return 16'h1F08;
            9:  return 16'h4409;
            10: return 16'b0011110000000000;
            default: return 16'hC000 | 16'(a);
        endcase
    endfunction

    // Behavioural memory: one-cycle read latency, output floats outside read slots.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.m_ce) begin
            if (bus.m_rw == RW_WRITE) ram[bus.m_addr] <= bus.m_wdata;
            else rdq <= ram[bus.m_addr];
        end
        rd_slot <= bus.m_ce && (bus.m_rw == RW_READ);
    end

    assign bus.m_rdata = rd_slot ? rdq : 16'hzzzz;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    task automatic set_idle(input int n);
        exp_tab[n].ce     = 1'b0;
        exp_tab[n].rw     = RW_READ;
        exp_tab[n].rw_chk = 1'b1;
        exp_tab[n].addr   = 8'h00;
        exp_tab[n].wdata  = 16'h0000;
        exp_tab[n].rdv    = 1'b0;
        exp_tab[n].rdata  = 16'h0000;
        exp_tab[n].last   = 1'b0;
        exp_tab[n].done   = 1'b0;
        exp_tab[n].rr     = 1'b1;
        exp_tab[n].wrr    = 1'b0;
    endtask

    // Single compare process against the expectation table, also recording a trace.
    always @(negedge clk) begin
        if (cmp_en && cyc < NCYC) begin
            cur_e = exp_tab[cyc];
            tr_ce[cyc]    = bus.m_ce;
            tr_addr[cyc]  = bus.m_addr;
            tr_wdata[cyc] = bus.m_wdata;
            tr_rdv[cyc]   = bus.rd_valid;
            tr_rdata[cyc] = bus.rd_data;
            tr_last[cyc]  = bus.rd_last;
            tr_done[cyc]  = bus.done;
            tr_rr[cyc]    = bus.req_ready;
            check_output("m_ce", 32'(bus.m_ce), 32'(cur_e.ce));
            if (cur_e.ce) check_output("m_addr", 32'(bus.m_addr), 32'(cur_e.addr));
            if (cur_e.rw_chk) check_output("m_rw", 32'(bus.m_rw), 32'(cur_e.rw));
            if (cur_e.ce && cur_e.rw == RW_WRITE) check_output("m_wdata", 32'(bus.m_wdata), 32'(cur_e.wdata));
            check_output("rd_valid", 32'(bus.rd_valid), 32'(cur_e.rdv));
            if (cur_e.rdv) check_output("rd_data", 32'(bus.rd_data), 32'(cur_e.rdata));
            check_output("rd_last", 32'(bus.rd_last), 32'(cur_e.last));
            check_output("done", 32'(bus.done), 32'(cur_e.done));
            check_output("req_ready", 32'(bus.req_ready), 32'(cur_e.rr));
            check_output("wr_ready", 32'(bus.wr_ready), 32'(cur_e.wrr));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        while (cyc < free_cyc) next_cycle();
    endtask

    // Read accepted at the end of cycle c: addresses in c+1..c+L, data in c+3..c+L+2.
    task automatic fill_read(input logic [7:0] a, input int len, input int c);
        if (len == 0) begin
            exp_tab[c+1].done = 1'b1;
            free_cyc = c + 1;
        end else begin
            for (int k = 1; k <= len; k++) begin
                exp_tab[c+k].ce     = 1'b1;
                exp_tab[c+k].rw     = RW_READ;
                exp_tab[c+k].rw_chk = 1'b1;
                exp_tab[c+k].addr   = 8'(a + 8'(k - 1));
            end
            for (int n = c + 1; n <= c + len + 2; n++) exp_tab[n].rr = 1'b0;
            for (int k = 0; k < len; k++) begin
                exp_tab[c+3+k].rdv   = 1'b1;
                exp_tab[c+3+k].rdata = ref_mem[8'(a + 8'(k))];
            end
            exp_tab[c+len+2].last = 1'b1;
            exp_tab[c+len+2].done = 1'b1;
            free_cyc = c + len + 3;
        end
    endtask

    task automatic apply_read(input logic [7:0] a, input int len, output int c);
        c = cyc;
        bus.req_valid = 1'b1;
        bus.req_rw    = RW_READ;
        bus.req_addr  = a;
        bus.req_len   = 9'(len);
        fill_read(a, len, c);
        next_cycle();
        bus.req_valid = 1'b0;
        wait_free();
    endtask

    task automatic mark_write_busy(input int n);
        exp_tab[n].rr  = 1'b0;
        exp_tab[n].wrr = 1'b1;
        if (!exp_tab[n].ce) exp_tab[n].rw_chk = 1'b0;
    endtask

    // Each accepted word appears on the bus the following cycle; done rides with the last one.
    task automatic apply_write(input logic [7:0] a, input int len, input logic [15:0] base,
                               input int stall_after, input int stall_len, output int c);
        c = cyc;
        bus.req_valid = 1'b1;
        bus.req_rw    = RW_WRITE;
        bus.req_addr  = a;
        bus.req_len   = 9'(len);
        bus.wr_valid  = 1'b0;
        if (len == 0) begin
            exp_tab[c+1].done = 1'b1;
            free_cyc = c + 1;
        end
        next_cycle();
        bus.req_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_after + 1) begin
                for (int s = 0; s < stall_len; s++) begin
                    mark_write_busy(cyc);
                    bus.wr_valid = 1'b0;
                    next_cycle();
                end
            end
            mark_write_busy(cyc);
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 16'(i);
            exp_tab[cyc+1].ce     = 1'b1;
            exp_tab[cyc+1].rw     = RW_WRITE;
            exp_tab[cyc+1].rw_chk = 1'b1;
            exp_tab[cyc+1].addr   = 8'(a + 8'(i));
            exp_tab[cyc+1].wdata  = base + 16'(i);
            ref_mem[8'(a + 8'(i))] = base + 16'(i);
            if (i == len - 1) begin
                exp_tab[cyc+1].done = 1'b1;
                free_cyc = cyc + 1;
            end
            next_cycle();
        end
        bus.wr_valid = 1'b0;
        wait_free();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int wc;
        int rc;
        logic [7:0] wrap_seq[4];

        clr           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rw    = RW_READ;
        bus.req_addr  = 8'h00;
        bus.req_len   = 9'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 16'h0000;
        for (int n = 0; n < NCYC; n++) set_idle(n);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        cmp_en = 1'b1;

        next_cycle();
        check_output("rst_m_ce", 32'(bus.m_ce), 32'h0);
        check_output("rst_m_rw", 32'(bus.m_rw), 32'h1);
        check_output("rst_m_addr", 32'(bus.m_addr), 32'h0);
        check_output("rst_m_wdata", 32'(bus.m_wdata), 32'h0);
        check_output("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_output("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check_output("rst_rd_last", 32'(bus.rd_last), 32'h0);
        check_output("rst_done", 32'(bus.done), 32'h0);
        check_output("rst_wr_ready", 32'(bus.wr_ready), 32'h0);
        check_output("rst_req_ready", 32'(bus.req_ready), 32'h1);
        next_cycle();
        clr = 1'b0;
        next_cycle();

        // Straight-line program read.
        apply_read(8'h00, 11, c);
        next_cycle();
        check_output("prog_first_valid", 32'(tr_rdv[c+3]), 32'h1);
        check_output("prog_word0", 32'(tr_rdata[c+3]), 32'h3803);
        check_output("prog_word10", 32'(tr_rdata[c+13]), 32'h3C00);
        check_output("prog_rd_last", 32'(tr_last[c+13]), 32'h1);
        check_output("prog_done", 32'(tr_done[c+13]), 32'h1);
        check_output("prog_ready_back", 32'(tr_rr[c+14]), 32'h1);

        // Write with a two-cycle stall after word 1, then read it back.
        apply_write(8'h20, 4, 16'hA5A0, 1, 2, c);
        next_cycle();
        check_output("wr_first_beat", 32'(tr_wdata[c+2]), 32'hA5A0);
        check_output("wr_gap_a", 32'(tr_ce[c+4]), 32'h0);
        check_output("wr_gap_b", 32'(tr_ce[c+5]), 32'h0);
        check_output("wr_last_beat", 32'(tr_wdata[c+7]), 32'hA5A3);
        check_output("wr_done", 32'(tr_done[c+7]), 32'h1);
        apply_read(8'h20, 4, c);
        next_cycle();
        check_output("rb_word0", 32'(tr_rdata[c+3]), 32'hA5A0);
        check_output("rb_word3", 32'(tr_rdata[c+6]), 32'hA5A3);

        // Address wrap at the top of memory.
        wrap_seq[0] = 8'hFE;
        wrap_seq[1] = 8'hFF;
        wrap_seq[2] = 8'h00;
        wrap_seq[3] = 8'h01;
        apply_read(8'hFE, 4, c);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            check_output("wrap_ce", 32'(tr_ce[c+1+k]), 32'h1);
            check_output("wrap_addr", 32'(tr_addr[c+1+k]), 32'(wrap_seq[k]));
        end

        // Zero-length request.
        apply_read(8'h10, 0, c);
        next_cycle();
        check_output("len0_done", 32'(tr_done[c+1]), 32'h1);
        check_output("len0_no_ce", 32'(tr_ce[c+1]), 32'h0);
        check_output("len0_ready", 32'(tr_rr[c+1]), 32'h1);

        // Asynchronous reset in cycle 2 of a len-8 read abandons the burst.
        c = cyc;
        bus.req_valid = 1'b1;
        bus.req_rw    = RW_READ;
        bus.req_addr  = 8'h08;
        bus.req_len   = 9'd8;
        fill_read(8'h08, 8, c);
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        #1;
        clr = 1'b1;
        for (int n = c + 2; n <= c + 14; n++) set_idle(n);
        #1;
        check_output("abort_m_ce", 32'(bus.m_ce), 32'h0);
        check_output("abort_rd_valid", 32'(bus.rd_valid), 32'h0);
        next_cycle();
        next_cycle();
        clr = 1'b0;
        free_cyc = cyc;
        next_cycle();
        check_output("abort_ready", 32'(bus.req_ready), 32'h1);
        repeat (10) next_cycle();

        // Back-to-back single write then single read of the same address.
        apply_write(8'h40, 1, 16'h1234, -1, 0, wc);
        apply_read(8'h40, 1, rc);
        next_cycle();
        check_output("b2b_wr_done", 32'(tr_done[wc+2]), 32'h1);
        check_output("b2b_rd_ce", 32'(tr_ce[wc+3]), 32'h1);
        check_output("b2b_rd_valid", 32'(tr_rdv[rc+3]), 32'h1);
        check_output("b2b_rd_data", 32'(tr_rdata[rc+3]), 32'h1234);

        repeat (3) next_cycle();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
